// File: rtl/hex_digit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hex_digit_sequencer
// Purpose  : Feeds a seven-segment encoder one hex digit at a time. A word
//            of NIBBLES digits is taken through a ready/start handshake and
//            shown most-significant digit first. Each digit is held for
//            DWELL_CYCLES clocks, then blanked for BLANK_CYCLES clocks so
//            that repeated digits stay distinguishable.
// Ports    : clk_i    - clock, rising edge
//            rst_ni   - asynchronous active-low reset
//            word_i   - word to display, sampled on an accepted start
//            start_i  - start request, taken only while ready_o is high
//            ready_o  - high while idle (a word can be accepted)
//            value_o  - {dot, nibble}; dot marks the first digit of a word
//            valid_o  - high while a digit is being shown
//            done_o   - one-cycle pulse on the first idle cycle after a word
// Revision : 1.0 - initial release
// ============================================================================
module hex_digit_sequencer #(
    parameter int NIBBLES      = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 250
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [4*NIBBLES-1:0]   word_i,
    input  logic                   start_i,
    output logic                   ready_o,
    output logic [4:0]             value_o,
    output logic                   valid_o,
    output logic                   done_o
);

    // Counter must reach the larger of the two terminal counts.
    localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q,   cnt_d;
    logic [IW-1:0]          idx_q,   idx_d;
    logic [4*NIBBLES-1:0]   word_q,  word_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [4:0]             value_q, value_d;
    logic                   done_q,  done_d;
    logic [3:0]             nib;

    // ------------------------------------------------------------------
    // Next-state logic. Outputs are derived from the *next* state so they
    // can be registered without adding a cycle of display latency.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
        done_d  = 1'b0;
        nib     = 4'h0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    word_d  = word_i;
                    idx_d   = LAST_IDX;
                    cnt_d   = '0;
                    state_d = SHOW;
                end
            end

            SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_d = BLANK;
                    end else if (idx_q != '0) begin
                        idx_d = idx_q - IW'(1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d = '0;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - IW'(1);
                        state_d = SHOW;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Select the nibble that will be on display after this edge.
        for (int k = 0; k < NIBBLES; k++) begin
            if (int'(idx_d) == k) begin
                nib = word_d[4*k +: 4];
            end
        end

        ready_d = (state_d == IDLE);
        valid_d = (state_d == SHOW);
        // value is only refreshed while showing; it holds through blank/idle.
        value_d = (state_d == SHOW) ? {(idx_d == LAST_IDX), nib} : value_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            value_q <= 5'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign value_o = value_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire
